// File: rtl/s3_writeback_regfile_pkg.sv
// Shared datapath dimensions for the S1/S2/S3 pipeline registers and the
// architectural register file.
package s3_writeback_regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/s3_writeback_regfile_regfile_2r1w.sv
// 2-read / 1-write architectural register file with asynchronous clear.
// Register 0 is hardwired to zero: writes are dropped and reads return 0.
module regfile_2r1w
    import s3_writeback_regfile_pkg::*;
#(
    parameter int DATA_W   = s3_writeback_regfile_pkg::DATA_W,
    parameter int ADDR_W   = s3_writeback_regfile_pkg::ADDR_W,
    parameter int NUM_REGS = s3_writeback_regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Entry 0 is cleared by reset and never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == REG_ZERO) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == REG_ZERO) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/s3_writeback_regfile.sv
// Writeback stage: S3 pipeline register, commit into the register file, and
// bypass of the in-flight S3 write onto both read ports.
module s3_writeback_regfile
    import s3_writeback_regfile_pkg::*;
#(
    parameter int DATA_W   = s3_writeback_regfile_pkg::DATA_W,
    parameter int ADDR_W   = s3_writeback_regfile_pkg::ADDR_W,
    parameter int NUM_REGS = s3_writeback_regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic [ADDR_W-1:0] S2_WriteSelect,
    input  logic              S2_WriteEnable,
    input  logic [ADDR_W-1:0] Reg_ReadSelect1,
    input  logic [ADDR_W-1:0] Reg_ReadSelect2,
    output logic [DATA_W-1:0] Reg_ReadData1,
    output logic [DATA_W-1:0] Reg_ReadData2,
    output logic [DATA_W-1:0] S3_WriteData,
    output logic [ADDR_W-1:0] S3_WriteSelect,
    output logic              S3_WriteEnable
);
    logic [DATA_W-1:0] s3_data_q, s3_data_d;
    logic [ADDR_W-1:0] s3_sel_q,  s3_sel_d;
    logic              s3_we_q,   s3_we_d;
    logic [DATA_W-1:0] raw_data1, raw_data2;

    assign s3_data_d = ALU_Out;
    assign s3_sel_d  = S2_WriteSelect;
    assign s3_we_d   = S2_WriteEnable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_data_q <= '0;
            s3_sel_q  <= '0;
            s3_we_q   <= 1'b0;
        end else begin
            s3_data_q <= s3_data_d;
            s3_sel_q  <= s3_sel_d;
            s3_we_q   <= s3_we_d;
        end
    end

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst),
        .we_i     (s3_we_q),
        .waddr_i  (s3_sel_q),
        .wdata_i  (s3_data_q),
        .raddr1_i (Reg_ReadSelect1),
        .raddr2_i (Reg_ReadSelect2),
        .rdata1_o (raw_data1),
        .rdata2_o (raw_data2)
    );

    // x0 check comes first so a pending write to r0 is never forwarded.
    always_comb begin
        Reg_ReadData1 = raw_data1;
        if (Reg_ReadSelect1 == REG_ZERO) begin
            Reg_ReadData1 = '0;
        end else if (s3_we_q && (Reg_ReadSelect1 == s3_sel_q)) begin
            Reg_ReadData1 = s3_data_q;
        end
    end

    always_comb begin
        Reg_ReadData2 = raw_data2;
        if (Reg_ReadSelect2 == REG_ZERO) begin
            Reg_ReadData2 = '0;
        end else if (s3_we_q && (Reg_ReadSelect2 == s3_sel_q)) begin
            Reg_ReadData2 = s3_data_q;
        end
    end

    assign S3_WriteData   = s3_data_q;
    assign S3_WriteSelect = s3_sel_q;
    assign S3_WriteEnable = s3_we_q;
endmodule

// File: tb/tb_s3_writeback_regfile.sv
// Self-checking bench for s3_writeback_regfile: scoreboard of S2 requests
// compared against S3 outputs and read ports one edge later.
module tb_s3_writeback_regfile;
    logic        clk;
    logic        rst;
    logic [31:0] ALU_Out;
    logic [4:0]  S2_WriteSelect;
    logic        S2_WriteEnable;
    logic [4:0]  Reg_ReadSelect1;
    logic [4:0]  Reg_ReadSelect2;
    logic [31:0] Reg_ReadData1;
    logic [31:0] Reg_ReadData2;
    logic [31:0] S3_WriteData;
    logic [4:0]  S3_WriteSelect;
    logic        S3_WriteEnable;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
        logic        we;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [31:0] mdl [32];

    s3_writeback_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .ALU_Out         (ALU_Out),
        .S2_WriteSelect  (S2_WriteSelect),
        .S2_WriteEnable  (S2_WriteEnable),
        .Reg_ReadSelect1 (Reg_ReadSelect1),
        .Reg_ReadSelect2 (Reg_ReadSelect2),
        .Reg_ReadData1   (Reg_ReadData1),
        .Reg_ReadData2   (Reg_ReadData2),
        .S3_WriteData    (S3_WriteData),
        .S3_WriteSelect  (S3_WriteSelect),
        .S3_WriteEnable  (S3_WriteEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one S2 request, clock it into S3, then compare against the scoreboard.
    task automatic do_cycle(input logic [4:0] sel, input logic [31:0] data, input logic we);
        sb_entry_t   e;
        logic [31:0] exp_rd;
        ALU_Out        = data;
        S2_WriteSelect = sel;
        S2_WriteEnable = we;
        e.sel = sel; e.data = data; e.we = we;
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble S2 inputs: outputs must not depend on them combinationally.
        ALU_Out        = $urandom;
        S2_WriteSelect = 5'($urandom_range(0, 31));
        S2_WriteEnable = 1'b0;
        e = sb.pop_front();
        if (e.we && e.sel != 5'd0) mdl[e.sel] = e.data;
        Reg_ReadSelect1 = e.sel;
        #1;
        exp_rd = (e.sel == 5'd0) ? 32'd0 : mdl[e.sel];
        checks++;
        if (S3_WriteData !== e.data || S3_WriteSelect !== e.sel || S3_WriteEnable !== e.we) begin
            errors++;
            $display("FAIL s3_reg: got data=%h sel=%0d we=%b, want data=%h sel=%0d we=%b",
                     S3_WriteData, S3_WriteSelect, S3_WriteEnable, e.data, e.sel, e.we);
        end
        checks++;
        if (Reg_ReadData1 !== exp_rd) begin
            errors++;
            $display("FAIL sb_read r%0d: got %h want %h", e.sel, Reg_ReadData1, exp_rd);
        end
        $display("txn sel=%0d data=%h we=%b -> S3 sel=%0d data=%h we=%b rd1=%h",
                 e.sel, e.data, e.we, S3_WriteSelect, S3_WriteData, S3_WriteEnable, Reg_ReadData1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ALU_Out         = $urandom;
            S2_WriteSelect  = 5'($urandom_range(0, 31));
            S2_WriteEnable  = 1'b1;
            Reg_ReadSelect1 = 5'($urandom_range(1, 31));
            Reg_ReadSelect2 = 5'($urandom_range(1, 31));
            #7;
            checks++;
            if (Reg_ReadData1 !== 32'd0 || Reg_ReadData2 !== 32'd0 || S3_WriteData !== 32'd0 ||
                S3_WriteSelect !== 5'd0 || S3_WriteEnable !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: rd1=%h rd2=%h s3d=%h s3s=%0d s3we=%b, want all 0",
                         Reg_ReadData1, Reg_ReadData2, S3_WriteData, S3_WriteSelect, S3_WriteEnable);
            end
        end
        @(negedge clk);
        S2_WriteEnable = 1'b0;
        rst = 1'b1;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            Reg_ReadSelect1 = 5'(r);
            Reg_ReadSelect2 = 5'(32 - r);
            #1;
            checks++;
            if (Reg_ReadData1 !== 32'd0 || Reg_ReadData2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_read r%0d/r%0d: got %h/%h want 0", r, 32 - r, Reg_ReadData1, Reg_ReadData2);
            end
        end
        $display("txn reset done");
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_cycle(5'd5, 32'hDEADBEEF, 1'b1);
        checks++;
        if (Reg_ReadData1 !== 32'hDEADBEEF || S3_WriteEnable !== 1'b1 || S3_WriteSelect !== 5'd5) begin
            errors++;
            $display("FAIL basic_bypass: rd1=%h we=%b sel=%0d want deadbeef 1 5",
                     Reg_ReadData1, S3_WriteEnable, S3_WriteSelect);
        end
        for (int i = 0; i < 2; i++) begin
            do_cycle(5'd12, 32'h0, 1'b0);
            Reg_ReadSelect2 = 5'd5; #1;
            checks++;
            if (Reg_ReadData2 !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL basic_array: rd2=%h want deadbeef", Reg_ReadData2);
            end
        end
    endtask

    task automatic test_r0();
        Reg_ReadSelect2 = 5'd0;
        do_cycle(5'd0, 32'h12345678, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (Reg_ReadData1 !== 32'd0 || Reg_ReadData2 !== 32'd0) begin
                errors++;
                $display("FAIL r0_read cyc%0d: rd1=%h rd2=%h want 0", i, Reg_ReadData1, Reg_ReadData2);
            end
            if (i == 0) do_cycle(5'd0, 32'hFFFFFFFF, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) do_cycle(5'd7, 32'(i + 1), 1'b1);
            else       do_cycle(5'd1, 32'hBAD0BAD0, 1'b0);
            Reg_ReadSelect2 = 5'd7; #1;
            checks++;
            if (Reg_ReadData2 !== want[i]) begin
                errors++;
                $display("FAIL b2b_r7 cyc%0d: rd2=%h want %h", i, Reg_ReadData2, want[i]);
            end
        end
    endtask

    task automatic test_we_low();
        do_cycle(5'd9, 32'h00000099, 1'b1);
        do_cycle(5'd9, 32'hFFFFFFFF, 1'b0);
        Reg_ReadSelect1 = 5'd9; Reg_ReadSelect2 = 5'd9; #1;
        checks++;
        if (Reg_ReadData1 !== 32'h99 || Reg_ReadData2 !== 32'h99 || S3_WriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL we_low_bypass: rd1=%h rd2=%h we=%b want 99 99 0",
                     Reg_ReadData1, Reg_ReadData2, S3_WriteEnable);
        end
        do_cycle(5'd2, 32'h0, 1'b0);
        Reg_ReadSelect1 = 5'd9; Reg_ReadSelect2 = 5'd9; #1;
        checks++;
        if (Reg_ReadData1 !== 32'h99 || Reg_ReadData2 !== 32'h99) begin
            errors++;
            $display("FAIL we_low_array: rd1=%h rd2=%h want 99", Reg_ReadData1, Reg_ReadData2);
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(5'd3, 32'hA5A5A5A5, 1'b1);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mdl[r] = 32'd0;
        #1;
        checks++;
        if (S3_WriteEnable !== 1'b0 || S3_WriteData !== 32'd0 || Reg_ReadData1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_async: we=%b data=%h rd1=%h want 0", S3_WriteEnable, S3_WriteData, Reg_ReadData1);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        Reg_ReadSelect1 = 5'd3; Reg_ReadSelect2 = 5'd7; #1;
        checks++;
        if (Reg_ReadData1 !== 32'd0 || Reg_ReadData2 !== 32'd0 || S3_WriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: r3=%h r7=%h we=%b want 0 0 0", Reg_ReadData1, Reg_ReadData2, S3_WriteEnable);
        end
        do_cycle(5'd4, 32'h00000044, 1'b1);
        do_cycle(5'd3, 32'h0, 1'b0);
        Reg_ReadSelect1 = 5'd4; Reg_ReadSelect2 = 5'd3; #1;
        checks++;
        if (Reg_ReadData1 !== 32'h44 || Reg_ReadData2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_after: r4=%h r3=%h want 44 0", Reg_ReadData1, Reg_ReadData2);
        end
    endtask

    initial begin
        rst = 1'b0;
        ALU_Out = '0; S2_WriteSelect = '0; S2_WriteEnable = 1'b0;
        Reg_ReadSelect1 = '0; Reg_ReadSelect2 = '0;
        for (int r = 0; r < 32; r++) mdl[r] = 32'd0;
        test_reset();
        test_basic();
        test_r0();
        test_back_to_back();
        test_we_low();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
